// File: rtl/skolem_sweep_ctrl_if.sv
// rtl/skolem_sweep_ctrl_if.sv - Signal bundle between the sweep controller, its Skolem netlist and the harness
// Controller side uses the master modport; netlist/harness side uses slave.
interface skolem_sweep_ctrl_if #(
  parameter int W = 4
);
  logic           start;
  logic [W-1:0]   sk_s;
  logic [W-1:0]   sk_t;
  logic [W-1:0]   sk_x;
  logic           busy;
  logic           done;
  logic           pass;
  logic [2*W:0]   err_cnt;
  logic           ff_valid;
  logic [W-1:0]   ff_s;
  logic [W-1:0]   ff_t;
  logic [W-1:0]   ff_x;

  modport master (
    input  start, sk_x,
    output sk_s, sk_t, busy, done, pass, err_cnt, ff_valid, ff_s, ff_t, ff_x
  );

  modport slave (
    output start, sk_x,
    input  sk_s, sk_t, busy, done, pass, err_cnt, ff_valid, ff_s, ff_t, ff_x
  );
endinterface

// File: rtl/skolem_sweep_ctrl.sv
// rtl/skolem_sweep_ctrl.sv - Exhaustive (s,t) sweep of a bvurem "not-equal" Skolem netlist with bit-serial remainder check
// Optional SKSWEEP_STOP_ON_FAIL_EN: end the sweep at the first failing pair.
module skolem_sweep_ctrl #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  skolem_sweep_ctrl_if.master bus
);
  localparam int IW = 2 * W;
  localparam int CW = 2 * W + 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DIV, S_CHK, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;

  logic [IW-1:0] r_idx;
  logic [SW-1:0] r_wcnt;
  logic [BW-1:0] r_b;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_rem;
  logic [CW-1:0] r_err;
  logic          r_ff_valid;
  logic [W-1:0]  r_ff_s;
  logic [W-1:0]  r_ff_t;
  logic [W-1:0]  r_ff_x;

  logic [W-1:0]  w_s;
  logic [W-1:0]  w_t;
  logic          w_start_ok;
  logic          w_last_settle;
  logic          w_last_bit;
  logic          w_fail;
  logic [W:0]    w_rp;
  logic [W-1:0]  w_rem_nxt;

  assign w_s           = r_idx[IW-1:W];
  assign w_t           = r_idx[W-1:0];
  assign w_start_ok    = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_settle = (r_wcnt == SW'(SETTLE - 1));
  assign w_last_bit    = (r_b == '0);
  assign w_fail        = (|r_idx) && (r_rem == w_t);

  // Restoring step: a subtracted result is below x, so W-bit arithmetic is exact.
  // x==0 always subtracts nothing and simply shifts s in, giving rem==s.
  assign w_rp      = {r_rem, w_s[r_b]};
  assign w_rem_nxt = (w_rp >= {1'b0, r_x}) ? (w_rp[W-1:0] - r_x) : w_rp[W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next = S_WAIT;
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        if (w_last_settle) w_next = S_DIV;
      end
      S_DIV: begin
        bus.busy = 1'b1;
        if (w_last_bit) w_next = S_CHK;
      end
      S_CHK: begin
        bus.busy = 1'b1;
        if (&r_idx) w_next = S_DONE;
`ifdef SKSWEEP_STOP_ON_FAIL_EN
        else if (w_fail) w_next = S_DONE;
`endif
        else w_next = S_WAIT;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (w_start_ok) w_next = S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_b        <= '0;
      r_x        <= '0;
      r_rem      <= '0;
      r_err      <= '0;
      r_ff_valid <= 1'b0;
      r_ff_s     <= '0;
      r_ff_t     <= '0;
      r_ff_x     <= '0;
    end else if (w_start_ok) begin
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_err      <= '0;
      r_ff_valid <= 1'b0;
      r_ff_s     <= '0;
      r_ff_t     <= '0;
      r_ff_x     <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_last_settle) begin
            r_x   <= bus.sk_x;
            r_rem <= '0;
            r_b   <= BW'(W - 1);
          end else begin
            r_wcnt <= r_wcnt + SW'(1);
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_b   <= r_b - BW'(1);
        end
        S_CHK: begin
          if (w_fail) begin
            r_err <= r_err + CW'(1);
            if (!r_ff_valid) begin
              r_ff_valid <= 1'b1;
              r_ff_s     <= w_s;
              r_ff_t     <= w_t;
              r_ff_x     <= r_x;
            end
          end
          if (w_next == S_WAIT) begin
            r_idx  <= r_idx + IW'(1);
            r_wcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sk_s     = w_s;
  assign bus.sk_t     = w_t;
  assign bus.err_cnt  = r_err;
  assign bus.pass     = (r_err == '0);
  assign bus.ff_valid = r_ff_valid;
  assign bus.ff_s     = r_ff_s;
  assign bus.ff_t     = r_ff_t;
  assign bus.ff_x     = r_ff_x;
endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// tb/tb_skolem_sweep_ctrl.sv - Scoreboard bench for skolem_sweep_ctrl against a brute-force bvurem reference
module tb_skolem_sweep_ctrl;
  localparam int W        = 4;
  localparam int SETTLE   = 1;
  localparam int NP       = 1 << (2 * W);
  localparam int PAIR_LAT = SETTLE + W + 1;
  localparam int M_GOOD   = 0;
  localparam int M_ZERO   = 1;
  localparam int M_ONE    = 2;
  localparam int M_RAND   = 3;

  typedef struct {
    int start_edge;
    int lat;
    int err;
    int pass;
    int ffv;
    int ffs;
    int fft;
    int ffx;
    int sks;
    int skt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mode = M_GOOD;
  int   gen = 0;
  int   rtab [NP];
  exp_t sb [$];
  exp_t me;
  logic prev_done = 1'b0;

  skolem_sweep_ctrl_if #(.W(W)) bus_if ();

  skolem_sweep_ctrl #(.W(W), .SETTLE(SETTLE)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int urem(int s, int x);
    return (x == 0) ? s : (s % x);
  endfunction

  function automatic int good_x(int s, int t);
    for (int x = 0; x < (1 << W); x++)
      if (urem(s, x) != t) return x;
    return 0;
  endfunction

  function automatic int x_for(int m, int s, int t);
    case (m)
      M_GOOD:  return good_x(s, t);
      M_ZERO:  return 0;
      M_ONE:   return 1;
      default: return rtab[s * (1 << W) + t];
    endcase
  endfunction

  always @(mode or gen or bus_if.sk_s or bus_if.sk_t)
    bus_if.sk_x = W'(x_for(mode, int'(bus_if.sk_s), int'(bus_if.sk_t)));

  function automatic exp_t model(int m);
    exp_t e;
    int   np;
    np = 0;
    e.err = 0; e.ffv = 0; e.ffs = 0; e.fft = 0; e.ffx = 0; e.sks = 0; e.skt = 0;
    for (int idx = 0; idx < NP; idx++) begin
      int s = idx >> W;
      int t = idx & ((1 << W) - 1);
      int x = x_for(m, s, t);
      bit f;
      np++;
      e.sks = s;
      e.skt = t;
      f = ((s != 0) || (t != 0)) && (urem(s, x) == t);
      if (f) begin
        e.err++;
        if (e.ffv == 0) begin
          e.ffv = 1; e.ffs = s; e.fft = t; e.ffx = x;
        end
`ifdef SKSWEEP_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    e.lat = np * PAIR_LAT + 1;
    e.pass = (e.err == 0) ? 1 : 0;
    e.start_edge = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_if.done && !prev_done) begin
      chk("done_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("done_latency", cyc - me.start_edge + 1, me.lat);
        chk("err_cnt", int'(bus_if.err_cnt), me.err);
        chk("pass", int'(bus_if.pass), me.pass);
        chk("ff_valid", int'(bus_if.ff_valid), me.ffv);
        if (me.ffv != 0) begin
          chk("ff_s", int'(bus_if.ff_s), me.ffs);
          chk("ff_t", int'(bus_if.ff_t), me.fft);
          chk("ff_x", int'(bus_if.ff_x), me.ffx);
        end
        chk("sk_s_final", int'(bus_if.sk_s), me.sks);
        chk("sk_t_final", int'(bus_if.sk_t), me.skt);
        chk("busy_at_done", int'(bus_if.busy), 0);
      end
    end
    prev_done <= bus_if.done;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, int'(bus_if.busy), 0);
    chk({tag, "_done"}, int'(bus_if.done), 0);
    chk({tag, "_ff_valid"}, int'(bus_if.ff_valid), 0);
    chk({tag, "_err_cnt"}, int'(bus_if.err_cnt), 0);
    chk({tag, "_pass"}, int'(bus_if.pass), 1);
    chk({tag, "_sk_s"}, int'(bus_if.sk_s), 0);
    chk({tag, "_sk_t"}, int'(bus_if.sk_t), 0);
    chk({tag, "_ff_s"}, int'(bus_if.ff_s), 0);
    chk({tag, "_ff_t"}, int'(bus_if.ff_t), 0);
    chk({tag, "_ff_x"}, int'(bus_if.ff_x), 0);
  endtask

  task automatic launch(input int m, input int abort_at, output bit pushed);
    exp_t e;
    @(negedge clk);
    mode = m;
    gen++;
    e = model(m);
    e.start_edge = cyc + 1;
    pushed = (abort_at == 0) || (e.lat < abort_at);
    if (pushed) sb.push_back(e);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NP; i++)
      rtab[i] = ($urandom_range(0, 3) == 0) ? good_x(i >> W, i & ((1 << W) - 1))
                                            : int'($urandom_range(0, (1 << W) - 1));
    gen++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit p;
    bus_if.start = 1'b0;
    rst_n = 1'b0;
    fill_rand();
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    // Correct witness, plus a start pulse while busy that must be ignored
    launch(M_GOOD, 0, p);
    repeat (98) @(negedge clk);
    chk("busy_mid_sweep", int'(bus_if.busy), 1);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_sb(3000);

    launch(M_ZERO, 0, p);
    wait_sb(3000);
    launch(M_ONE, 0, p);
    wait_sb(3000);

    for (int k = 0; k < 2; k++) begin
      fill_rand();
      launch(M_RAND, 0, p);
      wait_sb(3000);
    end

    // Mid-sweep reset, then a clean rerun
    launch(M_ZERO, 500, p);
    repeat (498) @(negedge clk);
    if (p) wait_sb(10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset("abort");
    launch(M_ZERO, 0, p);
    wait_sb(3000);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/skolem_sweep_ctrl.md
Name: skolem_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a combinational W-bit bvurem "not-equal" Skolem function netlist.
- It steps through every (s, t) operand pair and drives them to the netlist. It then samples the produced witness x and recomputes s urem x with a bit-serial restoring remainder unit.
- A pair fails if the invertibility condition holds and s urem x == t; failures are counted.
- Sits beside the generated netlist in the Skolem-function regression harness. The netlist needs no changes; its inputs/outputs are wired to sk_s/sk_t/sk_x at integration.

Parameters:
- W, 4, operand width of s, t and x.
- SETTLE, 1, cycles between driving sk_s/sk_t and sampling sk_x (≥1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse begins a sweep; ignored while busy=1.
- sk_s  out  W  registered s operand to the Skolem netlist.
- sk_t  out  W  registered t operand to the Skolem netlist.
- sk_x  in  W  witness x returned by the netlist (combinational).
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- done  out  1  level; high in DONE, cleared by the next accepted start.
- pass  out  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  out  2W+1  failing-pair count (max 2^(2W), no saturation needed).
- ff_valid  out  1  a first failure has been captured.
- ff_s / ff_t / ff_x  out  W each  operands and witness of the first failing pair.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. busy, done, ff_valid=0; err_cnt=0; sk_s=sk_t=0; ff_*=0. A reset mid-sweep aborts immediately with no partial done.
- Pair index idx is 2W bits: sk_s=idx[2W-1:W], sk_t=idx[W-1:0]. t varies fastest; idx runs from 0 to 2^(2W)-1.
- IDLE → WAIT on start. On that edge: idx=0, err_cnt=0, ff_valid=0, done=0, busy=1.
- WAIT: SETTLE cycles. On the last WAIT edge, capture x=sk_x, load rem=0 and bit counter b=W-1, go to DIV.
- DIV: W cycles, one quotient step per cycle, MSB first:
  - r' = {rem, s[b]} (W+1 bits);
  - rem = (r' >= x) ? r' - x : r'.
  - After the last step, rem equals s urem x in W bits.
  - x==0 yields rem==s, matching SMT-LIB bvurem semantics; implementations must not special-case it differently.
- CHK: one cycle.
  - pre = (s!=0) | (t!=0).
  - fail = pre & (rem==t).
  - If fail: err_cnt+1. If fail and ff_valid==0: latch ff_s/ff_t/ff_x and set ff_valid.
  - If idx is all-ones → DONE; else idx+1, sk_s/sk_t update on the same edge → WAIT.
- Pairs with pre==0 (s==0, t==0) are never counted, whatever x is.
- Per-pair latency: SETTLE+W+1 cycles (6 at defaults). Full sweep: 2^(2W)·(SETTLE+W+1) cycles (1536 at defaults).
- DONE: busy=0, done=1. Outputs hold. sk_s/sk_t hold the last pair. A start returns to the IDLE→WAIT path with a full re-init.
- A start pulse in any state other than IDLE/DONE is ignored.
- pass is combinational from err_cnt but meaningful only when done=1.

Optional Feature:
- Macro SKSWEEP_STOP_ON_FAIL_EN.
- Defined: a fail in CHK moves straight to DONE. idx, sk_s and sk_t hold the failing pair, err_cnt==1, pass=0.
- Undefined: the sweep always covers all pairs, and err_cnt is the total failure count.

Test Plan:
- sk_x driven by a correct bvurem-ne Skolem model (W=4), start at cycle 0 → done rises 1537 cycles after start; err_cnt=0, pass=1, ff_valid=0.
- sk_x tied to 0 → err_cnt=15 (s==t≠0); ff_s=1, ff_t=1, ff_x=0; pass=0.
- sk_x tied to 1 → err_cnt=15 (t==0, s≠0); ff_s=1, ff_t=0, ff_x=1.
- sk_x tied to 0, rst_n low for 1 cycle at cycle 500, then start again → all outputs reach reset values after that edge; the second sweep ends with err_cnt=15, with no residue from the aborted sweep.
- Correct model: pulse start again at cycle 100 (busy=1) → ignored; done still arrives 1537 cycles after the first start; err_cnt=0.
- With SKSWEEP_STOP_ON_FAIL_EN and sk_x tied to 0 → DONE after pair idx=17 (s=1, t=1), at 18·6+1 cycles; err_cnt=1, sk_s=1, sk_t=1, pass=0.
